// File: rtl/periph_bus_arb_if.sv
// Request/acknowledge and peripheral-bus control signals of periph_bus_arb.
// master: the arbiter side. slave: the requesters and peripherals facing it.
// The shared tri-state data bus stays a plain inout net on the arbiter.
interface periph_bus_arb_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 16
) ();

  logic [1:0]          req_vld;
  logic [1:0]          req_wr;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          ack;
  logic [DATA_W-1:0]   rd_data;
  logic [ADDR_W-1:0]   bus_addr;
  logic                bus_en;
  logic                bus_wr;

  modport master (
    input  req_vld, req_wr, req_addr, req_wdata,
    output ack, rd_data, bus_addr, bus_en, bus_wr
  );

  modport slave (
    output req_vld, req_wr, req_addr, req_wdata,
    input  ack, rd_data, bus_addr, bus_en, bus_wr
  );

endinterface

// File: rtl/periph_bus_arb.sv
// Two-port arbiter and sequencer for the shared peripheral register bus.
// Sequence per transfer: IDLE (arbitrate, latch) -> XFER (one bus strobe) -> ACK.
// Optional macro PERIPH_BUS_ARB_FIXED_PRIO_EN: port 0 always wins a tie.
// Default (undefined): round-robin on ties.
module periph_bus_arb #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  periph_bus_arb_if.master  bus,
  inout  wire  [DATA_W-1:0] bus_data
);

  typedef enum logic [1:0] {StIdle, StXfer, StAck} state_e;

  state_e              state_q;
  logic                gnt_q;
  logic                bus_en_q;
  logic                bus_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [1:0]          ack_q;
`ifndef PERIPH_BUS_ARB_FIXED_PRIO_EN
  logic                last_gnt_q;
`endif

  logic                win;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Pick the winning port and mux out its request fields.
  always_comb begin
    win = bus.req_vld[1];
    if (bus.req_vld == 2'b11) begin
`ifdef PERIPH_BUS_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last_gnt_q;
`endif
    end
    sel_wr    = win ? bus.req_wr[1] : bus.req_wr[0];
    sel_addr  = win ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
    sel_wdata = win ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
  end

  // Sequencer FSM; every bus-facing output is a register so nothing glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      bus_en_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      ack_q      <= 2'b00;
`ifndef PERIPH_BUS_ARB_FIXED_PRIO_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|bus.req_vld) begin
            gnt_q      <= win;
`ifndef PERIPH_BUS_ARB_FIXED_PRIO_EN
            last_gnt_q <= win;
`endif
            bus_wr_q   <= sel_wr;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            bus_en_q   <= 1'b1;
            state_q    <= StXfer;
          end
        end
        StXfer: begin
          // The peripheral drives the bus during a read; capture on the closing edge.
          if (!bus_wr_q) rd_data_q <= bus_data;
          bus_en_q <= 1'b0;
          bus_wr_q <= 1'b0;
          ack_q    <= gnt_q ? 2'b10 : 2'b01;
          state_q  <= StAck;
        end
        StAck: begin
          ack_q   <= 2'b00;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // bus_en_q is high only in XFER, so this driver can never overlap a peripheral read.
  assign bus_data     = (bus_en_q && bus_wr_q) ? wdata_q : {DATA_W{1'bz}};

  assign bus.ack      = ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.bus_addr = addr_q;
  assign bus.bus_en   = bus_en_q;
  assign bus.bus_wr   = bus_wr_q;

endmodule

// File: doc/periph_bus_arb.md
# periph_bus_arb

Two-port arbiter and sequencer for the shared peripheral bus (busAddr/busData/busEn/busWr) used by memory-mapped peripherals such as timer_16b. It accepts register read/write requests from two requesters (port 0, e.g. the core; port 1, e.g. a debug/DMA agent), grants one at a time, and drives a single-cycle bus access. It captures read data and returns a one-cycle acknowledge to the winner. It sits between the requesters and the peripherals, and is the only bus master that drives busEn/busWr.

## Interface
- ADDR_W, 2, width of the peripheral register address
- DATA_W, 16, width of the bus data

- clk  in  1  system clock; all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- reqVld  in  2  per-port request valid; held high until that port's ack
- reqWr  in  2  per-port direction: 1 = write, 0 = read
- reqAddr  in  2*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W]
- reqWdata  in  2*DATA_W  per-port write data; port i at [i*DATA_W +: DATA_W]
- ack  out  2  one-hot, one-cycle pulse: port's transfer complete
- rdData  out  DATA_W  captured read data; valid in ack cycle of a read, held after
- busAddr  out  ADDR_W  peripheral register address
- busData  inout  DATA_W  driven with write data only during a write XFER; Z otherwise
- busEn  out  1  bus access strobe
- busWr  out  1  bus direction during busEn

## Operation
- FSM states: IDLE, XFER, ACK.
- IDLE: if any reqVld, pick winner, latch its reqWr/reqAddr/reqWdata into internal registers, go XFER. Else stay.
- XFER: busEn=1, busWr=latched wr, busAddr=latched addr.
  - Write: busData driven with latched wdata; the peripheral latches it on the closing edge.
  - Read: busData released; arbiter samples busData into rdData on the closing edge.
  - Always go ACK.
- ACK: ack[winner]=1; bus idle; go IDLE. The requester drops or renews reqVld the cycle after ack.
- Arbitration is round-robin. lastGnt resets to 1, so port 0 wins first. On a tie, the port != lastGnt wins. lastGnt updates on each grant.
- Requests are sampled only in IDLE. A reqVld that rises during XFER/ACK waits. A reqVld that falls before ack is a protocol violation; the latched transfer still completes.
- Write-only transfers leave rdData unchanged.

## Timing
- Reset values: state=IDLE, ack=0, rdData=0, busEn=0, busWr=0, busAddr=0, busData=Z, lastGnt=1.
- Latency: request seen in IDLE at cycle N; XFER at N+1; ack and rdData valid at N+2.
- Throughput: one transfer per 3 cycles. With both ports requesting continuously, grants alternate 0,1,0,1…
- busEn is high for exactly one cycle per transfer and is never high in IDLE or ACK.
- busData is driven only while state=XFER and latched wr=1. There is no driver overlap with a peripheral read.
- Asynchronous reset mid-XFER: busEn drops and busData goes Z immediately. No ack is issued, and the pending request is re-arbitrated after reset release.

## Configuration
- PERIPH_BUS_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, port 0 always wins a tie; lastGnt is unused. Port 1 can starve.
  - Undefined (default): round-robin as above.

## Test plan
- Single write, port 0: reqVld=01, reqWr=01, reqAddr=0, wdata=0x1234 → cycle N+1 busEn=1, busWr=1, busAddr=0, busData=0x1234; cycle N+2 ack=01; timer register reads back 0x1234.
- Single read, port 1: peripheral returns 0xBEEF at addr 2 → busEn=1, busWr=0, busData Z from arbiter; ack=10 and rdData=0xBEEF at N+2.
- Both ports request continuously for 6 transfers → ack sequence 01,10,01,10,01,10, one ack every 3 cycles. With PERIPH_BUS_ARB_FIXED_PRIO_EN: all 6 acks are 01.
- Port 1 raises reqVld during port 0's XFER → port 1 is granted in the following IDLE; its ack comes 3 cycles after port 0's ack.
- Assert rstn=0 during XFER → busEn=0 and busData=Z in the same cycle, ack never pulses, all outputs at reset values. After release, the held request completes normally with ack=01.
- Back-to-back write then read on the same port (0x00AA, addr 1) → read returns 0x00AA. rdData stays unchanged across the write's ack.
